// File: rtl/lcd_win_ctrl_if.sv
// lcd_win_ctrl_if: host command, IROM read and IRAM write signals of the
// LCD window controller. The controller attaches through the slave modport;
// the host/memory side attaches through the master modport.
interface lcd_win_ctrl_if #(
   parameter int AW = 6,
   parameter int DW = 8
);
   logic [3:0]    cmd;
   logic          cmd_valid;
   logic [DW-1:0] IROM_Q;
   logic          IROM_rd;
   logic [AW-1:0] IROM_A;
   logic          IRAM_valid;
   logic [DW-1:0] IRAM_D;
   logic [AW-1:0] IRAM_A;
   logic          busy;
   logic          done;

   modport master (
      output cmd, cmd_valid, IROM_Q,
      input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
   );

   modport slave (
      input  cmd, cmd_valid, IROM_Q,
      output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
   );
endinterface

// File: rtl/lcd_win_ctrl.sv
// lcd_win_ctrl: loads an IMG_W x IMG_H frame from IROM into a pixel buffer,
// applies host commands to a movable 2x2 window and streams the frame to
// IRAM on request. Optional build macro LCDC_AVG_ROUND_EN selects
// round-half-up for the window average (truncation when undefined).
module lcd_win_ctrl #(
   parameter int IMG_W_LOG2 = 3,
   parameter int IMG_H_LOG2 = 3,
   parameter int DW         = 8
) (
   input  logic         clk,
   input  logic         reset,
   lcd_win_ctrl_if.slave bus
);
   localparam int XW = IMG_W_LOG2;
   localparam int YW = IMG_H_LOG2;
   localparam int AW = XW + YW;
   localparam int N  = 1 << AW;

   localparam logic [AW-1:0] LAST   = AW'(N - 1);
   localparam logic [XW-1:0] X_MAX  = XW'((1 << XW) - 2);
   localparam logic [YW-1:0] Y_MAX  = YW'((1 << YW) - 2);
   localparam logic [XW-1:0] X_INIT = XW'((1 << (XW - 1)) - 1);
   localparam logic [YW-1:0] Y_INIT = YW'((1 << (YW - 1)) - 1);

   localparam logic [3:0] CMD_WRITE  = 4'd0;
   localparam logic [3:0] CMD_UP     = 4'd1;
   localparam logic [3:0] CMD_DOWN   = 4'd2;
   localparam logic [3:0] CMD_LEFT   = 4'd3;
   localparam logic [3:0] CMD_RIGHT  = 4'd4;
   localparam logic [3:0] CMD_MAX    = 4'd5;
   localparam logic [3:0] CMD_MIN    = 4'd6;
   localparam logic [3:0] CMD_AVG    = 4'd7;
   localparam logic [3:0] CMD_CCW    = 4'd8;
   localparam logic [3:0] CMD_CW     = 4'd9;
   localparam logic [3:0] CMD_MIRX   = 4'd10;
   localparam logic [3:0] CMD_MIRY   = 4'd11;
   localparam logic [3:0] CMD_RELOAD = 4'd12;

   typedef enum logic [1:0] {ST_LOAD, ST_IDLE, ST_EXEC, ST_WRITE} state_t;

   state_t        state, next_state;
   logic [3:0]    cmd_q;
   logic [XW-1:0] org_x;
   logic [YW-1:0] org_y;
   logic          cap_en;
   logic [AW-1:0] cap_addr;
   logic          accept;
   logic [AW-1:0] wr_next;
   logic [DW-1:0] pix_buf [N];

   logic [AW-1:0] a0, a1, a2, a3;
   logic [DW-1:0] p0, p1, p2, p3;
   logic [DW-1:0] n0, n1, n2, n3;
   logic          op_wr;
   logic [DW-1:0] max01, max23, max_all, min01, min23, min_all, avg;
   logic [DW+1:0] pix_sum;

   assign accept   = (state == ST_IDLE) && bus.cmd_valid;
   assign bus.busy = (state != ST_IDLE);
   assign wr_next  = bus.IRAM_A + AW'(1);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!reset) state <= ST_LOAD;
      else        state <= next_state;
   end

   // Next-state decode.
   always_comb begin
      // NOTE: defaults first so every path assigns next_state; no latch.
      next_state = state;
      case (state)
         ST_LOAD:  if (cap_en && cap_addr == LAST) next_state = ST_IDLE;
         ST_IDLE:  if (accept) begin
                      if (bus.cmd == CMD_WRITE)       next_state = ST_WRITE;
                      else if (bus.cmd == CMD_RELOAD) next_state = ST_LOAD;
                      else                            next_state = ST_EXEC;
                   end
         ST_EXEC:  next_state = ST_IDLE;
         ST_WRITE: if (bus.IRAM_A == LAST) next_state = ST_IDLE;
         default:  next_state = ST_LOAD;
      endcase
   end

   // IROM address sequencer and one-cycle-delayed capture tag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.IROM_rd <= 1'b1;
         bus.IROM_A  <= '0;
         cap_en      <= 1'b0;
         cap_addr    <= '0;
      end else begin
         cap_en   <= bus.IROM_rd;
         cap_addr <= bus.IROM_A;
         if (accept && bus.cmd == CMD_RELOAD) begin
            bus.IROM_rd <= 1'b1;
            bus.IROM_A  <= '0;
         end else if (bus.IROM_rd) begin
            if (bus.IROM_A == LAST) bus.IROM_rd <= 1'b0;
            else                    bus.IROM_A  <= bus.IROM_A + AW'(1);
         end
      end
   end

   // Command latch and window origin movement with clamping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_q <= '0;
         org_x <= X_INIT;
         org_y <= Y_INIT;
      end else begin
         if (accept) cmd_q <= bus.cmd;
         if (state == ST_EXEC) begin
            case (cmd_q)
               CMD_UP:    if (org_y != '0)   org_y <= org_y - YW'(1);
               CMD_DOWN:  if (org_y != Y_MAX) org_y <= org_y + YW'(1);
               CMD_LEFT:  if (org_x != '0)   org_x <= org_x - XW'(1);
               CMD_RIGHT: if (org_x != X_MAX) org_x <= org_x + XW'(1);
               default: ;
            endcase
         end
      end
   end

   // Window addresses: row-major address is simply {y, x}.
   assign a0 = {org_y, org_x};
   assign a1 = {org_y, org_x + XW'(1)};
   assign a2 = {org_y + YW'(1), org_x};
   assign a3 = {org_y + YW'(1), org_x + XW'(1)};
   assign p0 = pix_buf[a0];
   assign p1 = pix_buf[a1];
   assign p2 = pix_buf[a2];
   assign p3 = pix_buf[a3];

   assign max01   = (p0 > p1) ? p0 : p1;
   assign max23   = (p2 > p3) ? p2 : p3;
   assign max_all = (max01 > max23) ? max01 : max23;
   assign min01   = (p0 < p1) ? p0 : p1;
   assign min23   = (p2 < p3) ? p2 : p3;
   assign min_all = (min01 < min23) ? min01 : min23;
   assign pix_sum = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
`ifdef LCDC_AVG_ROUND_EN
   assign avg = DW'((pix_sum + (DW + 2)'(2)) >> 2);
`else
   assign avg = DW'(pix_sum >> 2);
`endif

   // New window pixel values for the latched command.
   always_comb begin
      n0 = p0; n1 = p1; n2 = p2; n3 = p3;
      op_wr = 1'b1;
      case (cmd_q)
         CMD_MAX:  begin n0 = max_all; n1 = max_all; n2 = max_all; n3 = max_all; end
         CMD_MIN:  begin n0 = min_all; n1 = min_all; n2 = min_all; n3 = min_all; end
         CMD_AVG:  begin n0 = avg;     n1 = avg;     n2 = avg;     n3 = avg;     end
         CMD_CCW:  begin n0 = p1; n1 = p3; n2 = p0; n3 = p2; end
         CMD_CW:   begin n0 = p2; n1 = p0; n2 = p3; n3 = p1; end
         CMD_MIRX: begin n0 = p2; n1 = p3; n2 = p0; n3 = p1; end
         CMD_MIRY: begin n0 = p1; n1 = p0; n2 = p3; n3 = p2; end
         default:  op_wr = 1'b0;
      endcase
   end

   // Pixel buffer: frame capture during LOAD, window update on leaving EXEC.
   // NOTE: the buffer is deliberately not reset; a LOAD always refills it.
   always_ff @(posedge clk) begin
      if (state == ST_LOAD && cap_en) begin
         pix_buf[cap_addr] <= bus.IROM_Q;
      end else if (state == ST_EXEC && op_wr) begin
         pix_buf[a0] <= n0;
         pix_buf[a1] <= n1;
         pix_buf[a2] <= n2;
         pix_buf[a3] <= n3;
      end
   end

   // IRAM write-out stream and completion pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.IRAM_valid <= 1'b0;
         bus.IRAM_A     <= '0;
         bus.IRAM_D     <= '0;
         bus.done       <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (accept && bus.cmd == CMD_WRITE) begin
            bus.IRAM_valid <= 1'b1;
            bus.IRAM_A     <= '0;
            bus.IRAM_D     <= pix_buf[0];
         end else if (state == ST_WRITE) begin
            if (bus.IRAM_A == LAST) begin
               bus.IRAM_valid <= 1'b0;
               bus.done       <= 1'b1;
            end else begin
               bus.IRAM_A <= wr_next;
               bus.IRAM_D <= pix_buf[wr_next];
            end
         end
      end
   end
endmodule

// File: tb/tb_lcd_win_ctrl.sv
// tb_lcd_win_ctrl: self-checking bench for lcd_win_ctrl (8x8, 8-bit).
// A reference model of the buffer and window origin produces the expected
// write-out stream, queued on command issue and compared on IRAM strobes.
`timescale 1ns/1ps
module tb_lcd_win_ctrl;
   localparam int WL = 3;
   localparam int HL = 3;
   localparam int DW = 8;
   localparam int AW = WL + HL;
   localparam int N  = 1 << AW;
   localparam int W  = 1 << WL;
   localparam int H  = 1 << HL;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } pix_t;

   logic clk = 1'b0;
   logic reset = 1'b0;

   lcd_win_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   lcd_win_ctrl #(.IMG_W_LOG2(WL), .IMG_H_LOG2(HL), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // IROM model: one-cycle read latency
   logic [DW-1:0] rom [N];
   always @(posedge clk) if (bus.IROM_rd) bus.IROM_Q <= rom[bus.IROM_A];

   // reference model state
   logic [DW-1:0] mbuf [N];
   int mx, my;
   pix_t expq[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int idx(input int x, input int y);
      return y * W + x;
   endfunction

   task automatic model_reset();
      mx = W / 2 - 1;
      my = H / 2 - 1;
      for (int k = 0; k < N; k++) mbuf[k] = rom[k];
   endtask

   task automatic model_cmd(input int c);
      int i0, i1, i2, i3, s;
      logic [DW-1:0] q [4];
      logic [DW-1:0] r;
      i0 = idx(mx, my);     i1 = idx(mx + 1, my);
      i2 = idx(mx, my + 1); i3 = idx(mx + 1, my + 1);
      q[0] = mbuf[i0]; q[1] = mbuf[i1]; q[2] = mbuf[i2]; q[3] = mbuf[i3];
      r = q[0];
      case (c)
         1: if (my > 0) my--;
         2: if (my < H - 2) my++;
         3: if (mx > 0) mx--;
         4: if (mx < W - 2) mx++;
         5, 6, 7: begin
            if (c == 5) begin for (int i = 1; i < 4; i++) if (q[i] > r) r = q[i]; end
            else if (c == 6) begin for (int i = 1; i < 4; i++) if (q[i] < r) r = q[i]; end
            else begin
               s = int'(q[0]) + int'(q[1]) + int'(q[2]) + int'(q[3]);
`ifdef LCDC_AVG_ROUND_EN
               r = DW'((s + 2) / 4);
`else
               r = DW'(s / 4);
`endif
            end
            mbuf[i0] = r; mbuf[i1] = r; mbuf[i2] = r; mbuf[i3] = r;
         end
         8:  begin mbuf[i0] = q[1]; mbuf[i1] = q[3]; mbuf[i2] = q[0]; mbuf[i3] = q[2]; end
         9:  begin mbuf[i0] = q[2]; mbuf[i1] = q[0]; mbuf[i2] = q[3]; mbuf[i3] = q[1]; end
         10: begin mbuf[i0] = q[2]; mbuf[i1] = q[3]; mbuf[i2] = q[0]; mbuf[i3] = q[1]; end
         11: begin mbuf[i0] = q[1]; mbuf[i1] = q[0]; mbuf[i2] = q[3]; mbuf[i3] = q[2]; end
         12: for (int k = 0; k < N; k++) mbuf[k] = rom[k];
         default: ;
      endcase
   endtask

   // scoreboard: compare every IRAM strobe against the queued expectation
   always @(negedge clk) begin
      if (reset && bus.IRAM_valid) begin
         if (expq.size() == 0) begin
            check("sb_underflow", expq.size(), 1);
         end else begin
            pix_t e;
            e = expq.pop_front();
            check("iram_a", bus.IRAM_A, e.a);
            check("iram_d", bus.IRAM_D, e.d);
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_irom_rd"},    bus.IROM_rd, 1);
      check({tag, "_irom_a"},     bus.IROM_A, 0);
      check({tag, "_busy"},       bus.busy, 1);
      check({tag, "_iram_valid"}, bus.IRAM_valid, 0);
      check({tag, "_iram_a"},     bus.IRAM_A, 0);
      check({tag, "_iram_d"},     bus.IRAM_D, 0);
      check({tag, "_done"},       bus.done, 0);
   endtask

   // called at the negedge of LOAD cycle 0; counts busy cycles
   task automatic wait_load(input string tag);
      int cnt;
      cnt = 0;
      while (bus.busy && cnt < 200) begin
         if (cnt < N)  check("irom_a_seq", bus.IROM_A, cnt);
         if (cnt == N) check("irom_rd_fall", bus.IROM_rd, 0);
         check("done_in_load", bus.done, 0);
         cnt++;
         @(negedge clk);
      end
      check(tag, cnt, N + 1);
   endtask

   // called at a negedge; leaves cmd_valid high for 'hold' edges
   task automatic issue_cmd(input int c, input int hold);
      int t;
      t = 0;
      while (bus.busy && t < 300) begin @(negedge clk); t++; end
      check("ready_for_cmd", bus.busy, 0);
      bus.cmd       = c[3:0];
      bus.cmd_valid = 1'b1;
      if (c == 0) begin
         for (int k = 0; k < N; k++) expq.push_back('{a: AW'(k), d: mbuf[k]});
      end else begin
         model_cmd(c);
      end
      repeat (hold) @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic finish_write();
      int t, st;
      logic pv;
      logic [AW-1:0] pa;
      t = 0; st = 0; pv = 1'b0; pa = '0;
      while (!bus.done && t < 300) begin
         if (bus.IRAM_valid) st++;
         pv = bus.IRAM_valid;
         pa = bus.IRAM_A;
         @(negedge clk);
         t++;
      end
      check("done_seen", bus.done, 1);
      check("strobe_count", st, N);
      check("last_strobe_before_done", {pv, pa}, {1'b1, AW'(N - 1)});
      check("busy_with_done", bus.busy, 0);
      check("valid_with_done", bus.IRAM_valid, 0);
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
      check("sb_drained", expq.size(), 0);
   endtask

   task automatic write_out();
      issue_cmd(0, 1);
      finish_write();
   endtask

   task automatic reload();
      issue_cmd(12, 1);
      wait_load("reload_busy_cycles");
   endtask

   task automatic set_window(input int v0, input int v1, input int v2, input int v3);
      rom[27] = DW'(v0); rom[28] = DW'(v1); rom[35] = DW'(v2); rom[36] = DW'(v3);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      bus.cmd       = '0;
      bus.cmd_valid = 1'b0;
      for (int k = 0; k < N; k++) rom[k] = DW'(k);

      // reset state and initial load
      #12;
      check_reset_vals("rst");
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      wait_load("load_busy_cycles");
      write_out();
      write_out();

      // origin clamping: up x5, op; left x5, op; right x9, op
      repeat (5) issue_cmd(1, 1);
      issue_cmd(5, 1);
      repeat (5) issue_cmd(3, 1);
      issue_cmd(8, 1);
      repeat (9) issue_cmd(4, 1);
      issue_cmd(9, 1);
      issue_cmd(13, 1);
      issue_cmd(15, 1);
      write_out();

      // back to origin (3,3); reload keeps origin
      repeat (3) issue_cmd(3, 1);
      repeat (3) issue_cmd(2, 1);
      set_window(10, 20, 30, 41);
      reload();
      issue_cmd(5, 1);
      write_out();
      reload();
      issue_cmd(6, 1);
      write_out();
      reload();
      issue_cmd(7, 1);
      write_out();

      // rotations and mirrors
      set_window(1, 2, 3, 4);
      for (int c = 8; c <= 11; c++) begin
         reload();
         issue_cmd(c, 1);
         write_out();
      end

      // cmd_valid held through EXEC: one rotation only
      reload();
      issue_cmd(8, 2);
      write_out();

      // held for 4 edges: accepted on edges 0 and 2 -> two moves right
      issue_cmd(4, 4);
      model_cmd(4);
      issue_cmd(10, 1);
      write_out();

      // reset in the middle of WRITE at address 30
      issue_cmd(0, 1);
      t = 0;
      while (!(bus.IRAM_valid && bus.IRAM_A == AW'(30)) && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("reached_addr_30", bus.IRAM_A, 30);
      #2;
      reset = 1'b0;
      #1;
      check_reset_vals("midwrite_rst");
      expq.delete();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      wait_load("post_reset_busy_cycles");
      write_out();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
